// File: rtl/fir_lpf_param.sv
// rtl/fir_lpf_param.sv - parametrised pipelined streaming FIR low-pass filter
//
// Purpose: N_TAPS-tap FIR with a runtime coefficient bank (shadow + active,
// committed by coef_swap), valid-qualified input, a registered product stage,
// a registered binary adder tree and a round-half-up output stage.
// Latency from capture edge to out_valid: 2 + clog2(N_TAPS) edges.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid, in_data     sample stream input (no backpressure)
//   coef_we, coef_addr,
//   coef_data             shadow bank write port (out-of-range addresses ignored)
//   coef_swap             copy shadow bank into active bank
//   out_valid, out_data   filtered sample stream output
//   sat_flag              out_data was clipped (qualified by out_valid)
//
// Build option: define FIR_SAT_EN for saturating output; otherwise the rounded
// result wraps to OUT_W bits and sat_flag is tied low.

module fir_lpf_param #(
  parameter int N_TAPS    = 9,
  parameter int DATA_W    = 16,
  parameter int COEF_W    = 16,
  parameter int OUT_W     = 16,
  parameter int OUT_SHIFT = 14
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_valid,
  input  logic signed [DATA_W-1:0]    in_data,
  input  logic                        coef_we,
  input  logic [$clog2(N_TAPS)-1:0]   coef_addr,
  input  logic signed [COEF_W-1:0]    coef_data,
  input  logic                        coef_swap,
  output logic                        out_valid,
  output logic signed [OUT_W-1:0]     out_data,
  output logic                        sat_flag
);

  localparam int LV    = $clog2(N_TAPS);
  localparam int ACC_W = DATA_W + COEF_W + LV;

  // Unit gain coefficient; clipped when 1<<OUT_SHIFT does not fit COEF_W.
  localparam logic signed [COEF_W-1:0] COEF_MAX = {1'b0, {(COEF_W-1){1'b1}}};
  localparam logic signed [COEF_W-1:0] COEF_ONE =
    (OUT_SHIFT >= COEF_W - 1) ? COEF_MAX : COEF_W'(64'd1 << OUT_SHIFT);
  localparam logic signed [ACC_W-1:0]  HALF = ACC_W'(64'd1 << (OUT_SHIFT - 1));

  // Delay line: advances only on accepted samples.
  logic signed [DATA_W-1:0] tap_q [N_TAPS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < N_TAPS; k++) tap_q[k] <= '0;
    end else if (in_valid) begin
      tap_q[0] <= in_data;
      for (int k = 1; k < N_TAPS; k++) tap_q[k] <= tap_q[k-1];
    end
  end

  // Coefficient banks. A write and a swap on the same edge: the swap sees the
  // pre-write shadow because both update non-blocking.
  logic signed [COEF_W-1:0] shadow_q [N_TAPS];
  logic signed [COEF_W-1:0] active_q [N_TAPS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < N_TAPS; k++) shadow_q[k] <= (k == 0) ? COEF_ONE : '0;
    end else if (coef_we && (int'(coef_addr) < N_TAPS)) begin
      shadow_q[coef_addr] <= coef_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < N_TAPS; k++) active_q[k] <= (k == 0) ? COEF_ONE : '0;
    end else if (coef_swap) begin
      for (int k = 0; k < N_TAPS; k++) active_q[k] <= shadow_q[k];
    end
  end

  // Valid bit: [0] marks the capture edge, [LV+1] aligns with the tree root.
  logic [LV+1:0] vld_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) vld_q <= '0;
    else        vld_q <= {vld_q[LV:0], in_valid};
  end

  // Level 0 registers all products in one cycle from one bank; each further
  // level halves the node count, the odd last node passing straight through.
  for (genvar l = 0; l <= LV; l++) begin : g_lvl
    localparam int NL = (N_TAPS + (1 << l) - 1) >> l;
    localparam int NP = (2 * N_TAPS + (1 << l) - 1) >> l;
    logic signed [ACC_W-1:0] s_d [NL];
    logic signed [ACC_W-1:0] s_q [NL];

    for (genvar i = 0; i < NL; i++) begin : g_node
      if (l == 0) begin : g_mul
        assign s_d[i] = ACC_W'(tap_q[i] * active_q[i]);
      end else if (2 * i + 1 < NP) begin : g_add
        assign s_d[i] = g_lvl[l-1].s_q[2*i] + g_lvl[l-1].s_q[2*i+1];
      end else begin : g_pass
        assign s_d[i] = g_lvl[l-1].s_q[2*i];
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int j = 0; j < NL; j++) s_q[j] <= '0;
      end else begin
        for (int j = 0; j < NL; j++) s_q[j] <= s_d[j];
      end
    end
  end

  // Round half up, then arithmetic shift down to output scale.
  logic signed [ACC_W-1:0] r;
  logic signed [OUT_W-1:0] out_d;
  logic                    out_valid_q;
  logic signed [OUT_W-1:0] out_data_q;

  assign r = (g_lvl[LV].s_q[0] + HALF) >>> OUT_SHIFT;

`ifdef FIR_SAT_EN
  localparam logic signed [ACC_W-1:0] R_MAX = ACC_W'((64'd1 << (OUT_W - 1)) - 64'd1);
  localparam logic signed [ACC_W-1:0] R_MIN = ~R_MAX;

  logic sat_d;
  logic sat_q;

  always_comb begin
    out_d = r[OUT_W-1:0];
    sat_d = 1'b0;
    if (r > R_MAX) begin
      out_d = {1'b0, {(OUT_W-1){1'b1}}};
      sat_d = 1'b1;
    end else if (r < R_MIN) begin
      out_d = {1'b1, {(OUT_W-1){1'b0}}};
      sat_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sat_q <= 1'b0;
    else        sat_q <= vld_q[LV+1] & sat_d;
  end

  assign sat_flag = sat_q;
`else
  logic unused_r_hi;

  assign out_d       = r[OUT_W-1:0];
  assign unused_r_hi = ^r[ACC_W-1:OUT_W];
  assign sat_flag    = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      out_valid_q <= vld_q[LV+1];
      if (vld_q[LV+1]) out_data_q <= out_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

endmodule
